// File: rtl/mem_bus_pkg.sv
// Shared encodings for the IFU/LSU memory bus arbiter.
package mem_bus_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND      = 2'd1,
    WAIT_RESP = 2'd2,
    RETURN    = 2'd3
  } state_t;

  localparam logic       OWN_IFU    = 1'b0;
  localparam logic       OWN_LSU    = 1'b1;
  localparam logic [2:0] RTYPE_WORD = 3'b010;

endpackage

// File: rtl/mem_bus_grant.sv
// Combinational grant selector: fixed LSU priority or round-robin on ties.
module mem_bus_grant
  import mem_bus_pkg::*;
#(
  parameter int LSU_PRIORITY = 1
) (
  input  logic ifu_valid,
  input  logic lsu_valid,
  input  logic last_grant,
  output logic grant_ifu,
  output logic grant_lsu
);

  // Pick at most one requester from the current valids
  always_comb begin
    grant_ifu = 1'b0;
    grant_lsu = 1'b0;
    case ({ifu_valid, lsu_valid})
      2'b10: grant_ifu = 1'b1;
      2'b01: grant_lsu = 1'b1;
      2'b11: begin
        if (LSU_PRIORITY != 0) begin
          grant_lsu = 1'b1;
        end else if (last_grant == OWN_LSU) begin
          grant_ifu = 1'b1;
        end else begin
          grant_lsu = 1'b1;
        end
      end
      default: begin
        grant_ifu = 1'b0;
        grant_lsu = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Single-outstanding arbiter sharing one memory bus port between IFU and LSU,
// with a response timeout that forces an error reply from a hung slave.
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int LSU_PRIORITY = 1,
  parameter int TIMEOUT      = 255,
  parameter int CNT_W        = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ifu_req_valid,
  output logic        ifu_req_ready,
  input  logic [31:0] ifu_req_addr,
  output logic        ifu_resp_valid,
  input  logic        ifu_resp_ready,
  output logic [31:0] ifu_resp_rdata,
  output logic        ifu_resp_err,
  input  logic        lsu_req_valid,
  output logic        lsu_req_ready,
  input  logic [31:0] lsu_req_addr,
  input  logic        lsu_req_wen,
  input  logic [31:0] lsu_req_wdata,
  input  logic [7:0]  lsu_req_wmask,
  input  logic [2:0]  lsu_req_rtype,
  output logic        lsu_resp_valid,
  input  logic        lsu_resp_ready,
  output logic [31:0] lsu_resp_rdata,
  output logic        lsu_resp_err,
  output logic        bus_req_valid,
  input  logic        bus_req_ready,
  output logic [31:0] bus_req_addr,
  output logic        bus_req_wen,
  output logic [31:0] bus_req_wdata,
  output logic [7:0]  bus_req_wmask,
  output logic [2:0]  bus_req_rtype,
  input  logic        bus_resp_valid,
  output logic        bus_resp_ready,
  input  logic [31:0] bus_resp_rdata,
  input  logic        bus_resp_err
);

  localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);
  localparam logic             TO_EN  = (TIMEOUT != 0);

  state_t           state_r;
  state_t           state_nxt_s;
  logic             owner_r;
  logic             last_grant_r;
  logic             hist_r;
  logic [CNT_W-1:0] cnt_r;
  logic [31:0]      rdata_r;
  logic             err_r;

  logic grant_ifu_s;
  logic grant_lsu_s;
  logic eff_last_s;
  logic idle_s;
  logic hs_ifu_s;
  logic hs_lsu_s;
  logic timeout_s;
  logic owner_resp_ready_s;

  // Until the first grant, a tie goes to the IFU.
  assign eff_last_s = hist_r ? last_grant_r : OWN_LSU;

  mem_bus_grant #(
    .LSU_PRIORITY(LSU_PRIORITY)
  ) u_grant (
    .ifu_valid (ifu_req_valid),
    .lsu_valid (lsu_req_valid),
    .last_grant(eff_last_s),
    .grant_ifu (grant_ifu_s),
    .grant_lsu (grant_lsu_s)
  );

  assign idle_s        = rst && (state_r == IDLE);
  assign ifu_req_ready = idle_s && grant_ifu_s;
  assign lsu_req_ready = idle_s && grant_lsu_s;
  assign hs_ifu_s      = ifu_req_ready && ifu_req_valid;
  assign hs_lsu_s      = lsu_req_ready && lsu_req_valid;
  assign timeout_s     = TO_EN && (cnt_r == TO_VAL);

  assign owner_resp_ready_s = (owner_r == OWN_LSU) ? lsu_resp_ready : ifu_resp_ready;

  assign bus_req_valid  = (state_r == SEND);
  assign bus_resp_ready = (state_r == WAIT_RESP);
  assign ifu_resp_valid = (state_r == RETURN) && (owner_r == OWN_IFU);
  assign lsu_resp_valid = (state_r == RETURN) && (owner_r == OWN_LSU);
  assign ifu_resp_rdata = rdata_r;
  assign ifu_resp_err   = err_r;
  assign lsu_resp_rdata = rdata_r;
  assign lsu_resp_err   = err_r;

  // Next-state decode
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (hs_ifu_s || hs_lsu_s) state_nxt_s = SEND;
        else                      state_nxt_s = IDLE;
      end
      SEND: begin
        if (bus_req_ready) state_nxt_s = WAIT_RESP;
        else               state_nxt_s = SEND;
      end
      WAIT_RESP: begin
        if (bus_resp_valid || timeout_s) state_nxt_s = RETURN;
        else                             state_nxt_s = WAIT_RESP;
      end
      RETURN: begin
        if (owner_resp_ready_s) state_nxt_s = IDLE;
        else                    state_nxt_s = RETURN;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State, request latch, timeout counter and response registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r       <= IDLE;
      owner_r       <= OWN_IFU;
      last_grant_r  <= OWN_IFU;
      hist_r        <= 1'b0;
      cnt_r         <= '0;
      rdata_r       <= 32'd0;
      err_r         <= 1'b0;
      bus_req_addr  <= 32'd0;
      bus_req_wen   <= 1'b0;
      bus_req_wdata <= 32'd0;
      bus_req_wmask <= 8'd0;
      bus_req_rtype <= 3'd0;
    end else begin
      state_r <= state_nxt_s;
      case (state_r)
        IDLE: begin
          if (hs_lsu_s) begin
            bus_req_addr  <= lsu_req_addr;
            bus_req_wen   <= lsu_req_wen;
            bus_req_wdata <= lsu_req_wdata;
            bus_req_wmask <= lsu_req_wmask;
            bus_req_rtype <= lsu_req_rtype;
            owner_r       <= OWN_LSU;
            last_grant_r  <= OWN_LSU;
            hist_r        <= 1'b1;
          end else if (hs_ifu_s) begin
            bus_req_addr  <= ifu_req_addr;
            bus_req_wen   <= 1'b0;
            bus_req_wdata <= 32'd0;
            bus_req_wmask <= 8'd0;
            bus_req_rtype <= RTYPE_WORD;
            owner_r       <= OWN_IFU;
            last_grant_r  <= OWN_IFU;
            hist_r        <= 1'b1;
          end
        end
        SEND: begin
          if (bus_req_ready) cnt_r <= '0;
        end
        WAIT_RESP: begin
          // A real response beats a coincident timeout.
          if (bus_resp_valid) begin
            rdata_r <= bus_resp_rdata;
            err_r   <= bus_resp_err;
          end else if (timeout_s) begin
            rdata_r <= 32'd0;
            err_r   <= 1'b1;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        default: begin
          cnt_r <= cnt_r;
        end
      endcase
    end
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single memory bus port between the instruction fetch unit (IFU, read-only) and the M-stage load/store unit (LSU).
- Accepts one request at a time, owns the bus until the slave responds, then returns the response to the requester that issued it.
- Includes a response timeout so that a hung slave cannot deadlock the pipeline.
- Sits between IFU/M-stage and the memory/crossbar slave.

Parameters:
- LSU_PRIORITY, 1: 1 = fixed priority, LSU wins; 0 = round-robin on simultaneous requests.
- TIMEOUT, 255: maximum number of cycles spent in WAIT_RESP before an error response is forced; 0 disables the timeout.
- CNT_W, 8: width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  clock, all logic on the rising edge
- rst  in  1  reset, asynchronous, active-low
- ifu_req_valid  in  1  IFU read request valid
- ifu_req_ready  out  1  IFU request accepted
- ifu_req_addr  in  32  IFU fetch address
- ifu_resp_valid  out  1  IFU response valid
- ifu_resp_ready  in  1  IFU accepts the response
- ifu_resp_rdata  out  32  fetched word
- ifu_resp_err  out  1  bus error or timeout
- lsu_req_valid  in  1  LSU request valid
- lsu_req_ready  out  1  LSU request accepted
- lsu_req_addr  in  32  load/store address
- lsu_req_wen  in  1  1 = store
- lsu_req_wdata  in  32  store data
- lsu_req_wmask  in  8  byte write mask
- lsu_req_rtype  in  3  load type/size
- lsu_resp_valid  out  1  LSU response valid
- lsu_resp_ready  in  1  LSU accepts the response
- lsu_resp_rdata  out  32  load data
- lsu_resp_err  out  1  bus error or timeout
- bus_req_valid  out  1  request to the slave
- bus_req_ready  in  1  slave accepts the request
- bus_req_addr  out  32  registered address
- bus_req_wen  out  1  registered write enable
- bus_req_wdata  out  32  registered store data
- bus_req_wmask  out  8  registered mask
- bus_req_rtype  out  3  registered type; IFU requests drive 3'b010 (word)
- bus_resp_valid  in  1  slave response valid
- bus_resp_ready  out  1  arbiter accepts the response
- bus_resp_rdata  in  32  slave read data
- bus_resp_err  in  1  slave error

Behaviour:
- States: IDLE, SEND, WAIT_RESP, RETURN. Internal registers: owner (0 = IFU, 1 = LSU), last_grant, cnt.
- Reset (rst low, asynchronous):
  - state = IDLE, owner = 0, last_grant = 0, cnt = 0.
  - All bus_req_* registers are 0 and all response data/err registers are 0.
  - All valid and ready outputs are 0, except that the ready outputs follow the IDLE rules below once rst is released.
- IDLE:
  - Only the granted requester sees req_ready = 1. The handshake completes in the same cycle as valid & ready.
  - Grant rule: only one request valid → that requester is granted.
  - Both requests valid and LSU_PRIORITY = 1 → LSU is granted.
  - Both requests valid and LSU_PRIORITY = 0 → the requester that is not last_grant is granted.
  - On handshake: latch that requester's fields into bus_req_*, set owner and last_grant, and move to SEND.
  - For an IFU request: wen = 0, wmask = 0, wdata = 0, rtype = 3'b010.
- SEND:
  - bus_req_valid = 1, with fields held stable.
  - On bus_req_ready → WAIT_RESP, cnt = 0.
  - There is no timeout in SEND.
- WAIT_RESP:
  - bus_resp_ready = 1.
  - On bus_resp_valid: latch rdata and err → RETURN.
  - Otherwise cnt increments each cycle.
  - When TIMEOUT ≠ 0 and cnt == TIMEOUT with no response: latch rdata = 0 and err = 1 → RETURN.
  - A response arriving in the same cycle as the timeout wins, and its real data is used.
- RETURN:
  - The owner's resp_valid = 1, with registered rdata/err held stable. The non-owner's resp_valid = 0.
  - On the owner's resp_ready → IDLE.
- Latency:
  - Request accept → bus_req_valid: 1 cycle.
  - bus_resp_valid → master resp_valid: 1 cycle.
  - Best-case round trip, accept to resp_valid: 3 cycles.
- Other rules:
  - Both req_ready outputs are 0 outside IDLE, so there is never a second outstanding transaction.
  - A late response after a timeout is not accepted, because bus_resp_ready = 0 outside WAIT_RESP.
  - Reset in mid-transaction aborts immediately; no response is delivered for the aborted transaction.
  - Requester inputs are sampled only at the handshake, so changes while not ready are ignored.

Decomposition:
- Shared package mem_bus_pkg:
  - state encoding constants: IDLE = 2'd0, SEND = 2'd1, WAIT_RESP = 2'd2, RETURN = 2'd3
  - owner constants: OWN_IFU = 0, OWN_LSU = 1
  - RTYPE_WORD = 3'b010
- One sub-module: mem_bus_grant, the combinational grant selector.
  - Inputs: ifu_valid, lsu_valid, last_grant.
  - Outputs: grant_ifu, grant_lsu.
- The FSM, counter and datapath registers stay in the top module.

Test Plan:
1. Single IFU read: ifu_req_addr = 0x80000000, slave ready immediately, responds one cycle later with rdata = 0x00000413 → ifu_resp_valid 3 cycles after accept, rdata 0x00000413, err 0, lsu_resp_valid stays 0.
2. Simultaneous requests, LSU_PRIORITY = 1: LSU store addr = 0x80001000, wdata = 0xDEADBEEF, wmask = 8'h0F → LSU is granted first; bus shows wen = 1 with those values; IFU is granted only after lsu_resp handshake.
3. Round-robin, LSU_PRIORITY = 0, both requesters continuously valid for 4 transactions → grant order IFU, LSU, IFU, LSU from reset.
4. Backpressure: bus_req_ready low for 5 cycles, then lsu_resp_ready low for 3 cycles → bus_req fields stable throughout; LSU resp_valid held with stable data until ready; no new grant in the meantime.
5. Timeout, TIMEOUT = 4, slave never responds → owner resp_valid with err = 1, rdata = 0 exactly 5 cycles after entering WAIT_RESP; a later bus_resp_valid is not acknowledged.
6. Reset asserted in WAIT_RESP → all valids 0 immediately (asynchronously); after release, a fresh IFU request completes normally.
